// File: rtl/line_serializer.sv
// Read side of the video line buffer: double-buffered capture of a character-row
// bitmap, serialized one pixel per enabled cycle during active video.
module line_serializer #(
    parameter int unsigned WIDTH = 640,
    parameter int unsigned CNT_W = 10
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [0:WIDTH-1] LINE_IN,
    input  logic             LOAD,
    input  logic             START,
    input  logic             PIX_EN,
    output logic             PIXEL,
    output logic             ACTIVE,
    output logic             LINE_DONE,
    output logic             NEXT_REQ,
    output logic             UNDERRUN,
    output logic             OVERRUN
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(WIDTH - 1);

    logic [0:0]       state_q,     state_d;
    logic [0:WIDTH-1] shadow_q,    shadow_d;
    logic [0:WIDTH-1] shift_q,     shift_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             full_q,      full_d;
    logic             pixel_q,     pixel_d;
    logic             active_q,    active_d;
    logic             line_done_q, line_done_d;
    logic             next_req_q,  next_req_d;
    logic             underrun_q,  underrun_d;
    logic             overrun_q,   overrun_d;
    logic             transfer;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        full_d      = full_q;
        pixel_d     = pixel_q;
        line_done_d = 1'b0;
        underrun_d  = 1'b0;
        overrun_d   = 1'b0;
        transfer    = (state_q == ST_IDLE) && START && full_q;

        case (state_q)
            ST_IDLE: begin
                pixel_d = 1'b0;
                if (START) begin
                    if (full_q) begin
                        shift_d = shadow_q;
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                // START is deliberately ignored here, including on the last pixel.
                if (PIX_EN) begin
                    pixel_d = shift_q[0];
                    shift_d = {shift_q[1:WIDTH-1], 1'b0};
                    if (cnt_q == LAST_PIX) begin
                        cnt_d       = '0;
                        state_d     = ST_IDLE;
                        line_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A load coinciding with a transfer refills the shadow, so it stays full
        // and no request for another line is raised.
        if (LOAD) begin
            shadow_d  = LINE_IN;
            full_d    = 1'b1;
            overrun_d = full_q && !transfer;
        end else if (transfer) begin
            full_d = 1'b0;
        end

        next_req_d = transfer && !LOAD;
        active_d   = (state_d == ST_SHIFT);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            pixel_q     <= 1'b0;
            active_q    <= 1'b0;
            line_done_q <= 1'b0;
            next_req_q  <= 1'b0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            pixel_q     <= pixel_d;
            active_q    <= active_d;
            line_done_q <= line_done_d;
            next_req_q  <= next_req_d;
            underrun_q  <= underrun_d;
            overrun_q   <= overrun_d;
        end
    end

    assign PIXEL     = pixel_q;
    assign ACTIVE    = active_q;
    assign LINE_DONE = line_done_q;
    assign NEXT_REQ  = next_req_q;
    assign UNDERRUN  = underrun_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_line_serializer.sv
// Self-checking bench for line_serializer against an index-based line model.
module tb_line_serializer;

    localparam int W = 640;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [0:W-1] LINE_IN = '1;
    logic         LOAD = 1'b1;
    logic         START = 1'b0;
    logic         PIX_EN = 1'b0;
    logic         PIXEL, ACTIVE, LINE_DONE, NEXT_REQ, UNDERRUN, OVERRUN;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    line_serializer #(.WIDTH(W), .CNT_W(10)) dut (
        .CLK(CLK), .RESET(RESET), .LINE_IN(LINE_IN), .LOAD(LOAD), .START(START),
        .PIX_EN(PIX_EN), .PIXEL(PIXEL), .ACTIVE(ACTIVE), .LINE_DONE(LINE_DONE),
        .NEXT_REQ(NEXT_REQ), .UNDERRUN(UNDERRUN), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    // Reference model: a pending line, a line being displayed and a pixel index.
    logic [0:W-1] m_shadow, m_line;
    bit m_full, m_busy, m_pix, m_done, m_nreq, m_under, m_over;
    int m_idx;

    function automatic void m_reset();
        m_shadow = '0; m_line = '0; m_full = 0; m_busy = 0; m_idx = 0;
        m_pix = 0; m_done = 0; m_nreq = 0; m_under = 0; m_over = 0;
    endfunction

    function automatic void m_edge(bit ld, bit st, bit pe, logic [0:W-1] ln);
        bit xfer;
        xfer    = !m_busy && st && m_full;
        m_under = !m_busy && st && !m_full;
        m_over  = ld && m_full && !xfer;
        m_nreq  = xfer && !ld;
        m_done  = 0;
        if (m_busy) begin
            if (pe) begin
                m_pix = m_line[m_idx];
                m_idx++;
                if (m_idx == W) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else begin
            m_pix = 0;
            if (xfer) begin
                m_line = m_shadow;
                m_idx  = 0;
                m_busy = 1;
            end
        end
        if (ld) begin
            m_shadow = ln;
            m_full   = 1;
        end else if (xfer) begin
            m_full = 0;
        end
    endfunction

    function automatic logic [5:0] outs();
        return {PIXEL, ACTIVE, LINE_DONE, NEXT_REQ, UNDERRUN, OVERRUN};
    endfunction

    function automatic logic [5:0] expv();
        return {m_pix, m_busy, m_done, m_nreq, m_under, m_over};
    endfunction

    function automatic logic [0:W-1] rand_line();
        logic [0:W-1] v;
        for (int i = 0; i < W; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    task automatic step(input bit ld, input bit st, input bit pe, input logic [0:W-1] ln);
        LOAD = ld; START = st; PIX_EN = pe; LINE_IN = ln;
        @(posedge CLK);
        m_edge(ld, st, pe, ln);
        #1;
        cyc++;
    endtask

    task automatic pulse_reset();
        #2 RESET = 1'b0;
        LOAD = 0; START = 0; PIX_EN = 0;
        m_reset();
        #2 RESET = 1'b1;
    endtask

    task automatic test_reset();
        m_reset();
        #23;
        checks++;
        if (outs() !== 6'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", outs(), 6'b0);
        end
        #7 RESET = 1'b1;
        step(1, 0, 0, '1);
        checks++;
        if (outs() !== expv()) begin
            errors++; $display("FAIL reset_release_load: got %b expected %b", outs(), expv());
        end
        step(0, 0, 0, '0);
        checks++;
        if (OVERRUN !== 1'b0 || outs() !== expv()) begin
            errors++; $display("FAIL reset_no_overrun: got %b expected %b", outs(), expv());
        end
        pulse_reset();
    endtask

    task automatic test_basic();
        logic [0:W-1] l;
        int act = 0, nreq = 0, done = 0;
        l = '0; l[0] = 1'b1; l[W-1] = 1'b1;
        step(1, 0, 1, l);
        checks++;
        if (outs() !== expv()) begin
            errors++; $display("FAIL basic_load cyc=%0d: got %b expected %b", cyc, outs(), expv());
        end
        step(0, 1, 1, '0);
        act += int'(ACTIVE); nreq += int'(NEXT_REQ);
        for (int i = 0; i < W + 4; i++) begin
            checks++;
            if (outs() !== expv()) begin
                errors++; $display("FAIL basic_line cyc=%0d: got %b expected %b", cyc, outs(), expv());
            end
            step(0, 0, 1, '0);
            act += int'(ACTIVE); nreq += int'(NEXT_REQ); done += int'(LINE_DONE);
        end
        checks++;
        if (act != W || nreq != 1 || done != 1 || PIXEL !== 1'b0) begin
            errors++;
            $display("FAIL basic_counts: got act=%0d nreq=%0d done=%0d pix=%b expected act=%0d nreq=1 done=1 pix=0",
                     act, nreq, done, PIXEL, W);
        end
    endtask

    task automatic test_gating();
        int act = 0;
        step(1, 0, 0, rand_line());
        step(0, 1, 0, '0);
        act += int'(ACTIVE);
        for (int i = 0; i < 2 * W + 6; i++) begin
            step(0, 0, bit'(i % 2), '0);
            act += int'(ACTIVE);
            checks++;
            if (outs() !== expv()) begin
                errors++; $display("FAIL gating cyc=%0d: got %b expected %b", cyc, outs(), expv());
            end
        end
        checks++;
        if (act != 2 * W) begin
            errors++; $display("FAIL gating_active_span: got %0d expected %0d", act, 2 * W);
        end
    endtask

    task automatic test_double_buffer();
        int errp = 0;
        logic [0:W-1] b;
        b = rand_line();
        step(1, 0, 1, rand_line());
        step(0, 1, 1, '0);
        for (int line = 0; line < 2; line++) begin
            for (int i = 0; i < W + 3; i++) begin
                step(bit'(line == 0 && i == 99), 0, 1, b);
                errp += int'(UNDERRUN) + int'(OVERRUN);
                checks++;
                if (outs() !== expv()) begin
                    errors++; $display("FAIL double_buffer cyc=%0d: got %b expected %b", cyc, outs(), expv());
                end
            end
            if (line == 0) step(0, 1, 1, '0);
        end
        checks++;
        if (errp != 0) begin
            errors++; $display("FAIL double_buffer_err_pulses: got %0d expected 0", errp);
        end
    endtask

    task automatic test_load_start();
        int ovr = 0;
        step(1, 0, 1, rand_line());
        step(1, 1, 1, rand_line());
        checks++;
        if (NEXT_REQ !== 1'b0 || OVERRUN !== 1'b0 || outs() !== expv()) begin
            errors++; $display("FAIL load_start_same_cycle: got %b expected %b", outs(), expv());
        end
        for (int i = 0; i < W + 3; i++) begin
            step(bit'(i == 50), 0, 1, rand_line());
            ovr += int'(OVERRUN);
            checks++;
            if (outs() !== expv()) begin
                errors++; $display("FAIL load_start_line cyc=%0d: got %b expected %b", cyc, outs(), expv());
            end
        end
        step(0, 1, 1, '0);
        for (int i = 0; i < W + 3; i++) begin
            step(0, 0, 1, '0);
            checks++;
            if (outs() !== expv()) begin
                errors++; $display("FAIL load_start_retained cyc=%0d: got %b expected %b", cyc, outs(), expv());
            end
        end
        checks++;
        if (ovr != 1) begin
            errors++; $display("FAIL overrun_count: got %0d expected 1", ovr);
        end
    endtask

    task automatic test_underrun();
        int ones = 0;
        step(0, 1, 1, '0);
        checks++;
        if (UNDERRUN !== 1'b1 || outs() !== expv()) begin
            errors++; $display("FAIL underrun_pulse: got %b expected %b", outs(), expv());
        end
        for (int i = 0; i < W + 10; i++) begin
            step(0, 0, 1, '0);
            ones += int'(PIXEL) + int'(UNDERRUN);
        end
        checks++;
        if (ones != 0) begin
            errors++; $display("FAIL underrun_quiet: got %0d high samples expected 0", ones);
        end
    endtask

    task automatic test_reset_midline();
        int done = 0;
        step(1, 0, 1, '1);
        step(0, 1, 1, '0);
        for (int i = 0; i < 300; i++) step(0, 0, 1, '0);
        #2 RESET = 1'b0;
        #1;
        m_reset();
        checks++;
        if (ACTIVE !== 1'b0 || PIXEL !== 1'b0 || outs() !== 6'b0) begin
            errors++; $display("FAIL reset_midline_async: got %b expected %b", outs(), 6'b0);
        end
        #1 RESET = 1'b1;
        for (int i = 0; i < W; i++) begin
            step(0, 0, 1, '0);
            done += int'(LINE_DONE);
        end
        checks++;
        if (done != 0 || outs() !== expv()) begin
            errors++; $display("FAIL reset_midline_no_done: got done=%0d outs=%b expected done=0 outs=%b",
                               done, outs(), expv());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            step(bit'($urandom_range(0, 49) == 0), bit'($urandom_range(0, 39) == 0),
                 bit'($urandom_range(0, 3) != 0), rand_line());
            checks++;
            if (outs() !== expv()) begin
                errors++; $display("FAIL random cyc=%0d: got %b expected %b", cyc, outs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gating();
        test_double_buffer();
        test_load_start();
        test_underrun();
        test_reset_midline();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
